std_rr_slot_arbiter: RTL

Round-robin arbiter that shares a single registered output slot between N_REQ valid/ready requesters. Each cycle it grants at most one requester and captures that requester's payload and source index into the slot. Downstream drains the slot over a valid/ready handshake. It is the standard front-end for any single-ported shared resource in the core: a bus master port, a CSR write port, or a writeback port.

---
 rtl/std_rr_slot_arbiter_pkg.sv | 15 +
 rtl/std_dffr.sv | 20 ++
 rtl/std_rr_slot_arbiter_pick.sv | 34 +++
 rtl/std_rr_slot_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/std_rr_slot_arbiter_pkg.sv
// Shared types and helpers for the round-robin slot arbiter.
// Holds the slot state encoding and the pointer wrap-increment helper.
package std_rr_slot_arbiter_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Next search start after a grant; the last requester wraps back to 0.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/std_dffr.sv
// Generic D flip-flop with synchronous active-low reset.
// Used for the slot payload, source index and priority pointer.
module std_dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/std_rr_slot_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Works for any N_REQ, not only powers of two.
module std_rr_pick #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned SRC_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]     req,
  input  logic [SRC_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]     grant,
  output logic [SRC_WIDTH-1:0] winner,
  output logic                 any_req
);

  int unsigned idx;

  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        grant[idx]  = 1'b1;
        winner      = SRC_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/std_rr_slot_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output slot.
// Drain and refill can happen in the same cycle, so throughput is one per cycle.
module std_rr_slot_arbiter
  import std_rr_slot_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned SRC_WIDTH = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [SRC_WIDTH-1:0]        out_src,
  input  logic                        out_ready
);

  slot_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SRC_WIDTH-1:0]  src_q, src_d;
  logic [SRC_WIDTH-1:0]  ptr_q, ptr_d;

  logic [N_REQ-1:0]      grant;
  logic [SRC_WIDTH-1:0]  winner;
  logic                  any_req;
  logic                  can_accept;
  logic                  xfer;

  std_rr_pick #(
    .N_REQ     (N_REQ),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .winner  (winner),
    .any_req (any_req)
  );

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

  // Gating with resetn keeps any handshake from completing in a reset cycle.
  always_comb begin
    can_accept = ~out_valid | out_ready;
    xfer       = resetn & can_accept & any_req;
    req_ready  = xfer ? grant : '0;

    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = SLOT_FULL;
      data_d  = req_data[32'(winner) * DATA_WIDTH +: DATA_WIDTH];
      src_d   = winner;
      ptr_d   = SRC_WIDTH'(rr_wrap_inc(32'(winner), N_REQ));
    end else if (out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  std_dffr #(.WIDTH(DATA_WIDTH)) u_data_reg (
    .clk    (clk),
    .resetn (resetn),
    .d      (data_d),
    .q      (data_q)
  );

  std_dffr #(.WIDTH(SRC_WIDTH)) u_src_reg (
    .clk    (clk),
    .resetn (resetn),
    .d      (src_d),
    .q      (src_q)
  );

  std_dffr #(.WIDTH(SRC_WIDTH)) u_ptr_reg (
    .clk    (clk),
    .resetn (resetn),
    .d      (ptr_d),
    .q      (ptr_q)
  );

endmodule
